div_acc_engine: RTL

- Divide accelerator that sits directly downstream of the core controller.
- Consumes the controller's divide-loop detection pulse together with the captured dividend and divisor.
- Computes the result that the software repeated-subtraction loop would leave behind, in a fixed number of cycles.
- Writes the loop's architectural results back (quotient in memory, remainder in memory and in D) and redirects the PC past the loop. The pipeline is stalled while it works.

---
 rtl/div_acc_engine.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_acc_engine.sv
// Divide accelerator: replaces the software repeated-subtraction loop with a fixed-latency divider.
// Optional macro DIV_ACC_RADIX4_EN selects a radix-4 CALC stage (8 cycles instead of 16).
module div_acc_engine #(
  parameter int WIDTH  = 16,
  parameter int Q_ADDR = 1,
  parameter int R_ADDR = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             StartDiv102,
  input  logic [WIDTH-1:0] Divident,
  input  logic [WIDTH-1:0] Divisor,
  input  logic [WIDTH-1:0] ExitPc,
  input  logic             Abort,
  output logic             AccBusy,
  output logic             AccMemWrEn,
  output logic [WIDTH-1:0] AccMemAddr,
  output logic [WIDTH-1:0] AccMemWrData,
  output logic             AccDWrEn,
  output logic [WIDTH-1:0] AccDData,
  output logic             AccPcWrEn,
  output logic [WIDTH-1:0] AccPc,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_WRQ, S_WRR, S_DONE} state_t;

`ifdef DIV_ACC_RADIX4_EN
  localparam logic [4:0] CNT_INIT = 5'd7;

  // One radix-4 restoring step: returns {remainder, shifted dividend/quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] n,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH+1:0] trial, d1, d2, d3;
    logic [1:0]       digit;
    trial = {rem, n[WIDTH-1:WIDTH-2]};
    d1    = {2'b00, d};
    d2    = {1'b0, d, 1'b0};
    d3    = d1 + d2;
    if (trial >= d3) begin
      trial = trial - d3;
      digit = 2'd3;
    end else if (trial >= d2) begin
      trial = trial - d2;
      digit = 2'd2;
    end else if (trial >= d1) begin
      trial = trial - d1;
      digit = 2'd1;
    end else begin
      digit = 2'd0;
    end
    return {trial[WIDTH-1:0], n[WIDTH-3:0], digit};
  endfunction
`else
  localparam logic [4:0] CNT_INIT = 5'd15;

  // One radix-2 restoring step: returns {remainder, shifted dividend/quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] n,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] trial;
    logic           bit_q;
    trial = {rem, n[WIDTH-1]};
    bit_q = (trial >= {1'b0, d});
    if (bit_q) trial = trial - {1'b0, d};
    return {trial[WIDTH-1:0], n[WIDTH-2:0], bit_q};
  endfunction
`endif

  // Turn the floor division into the loop's ceil semantics; returns {Q, R}.
  function automatic logic [2*WIDTH-1:0] fix_result(input logic             neg,
                                                    input logic [WIDTH-1:0] n,
                                                    input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] d);
    if (neg)              return {WIDTH'(1), n - d};
    else if (rem != '0)   return {n + WIDTH'(1), rem - d};
    else                  return {n, {WIDTH{1'b0}}};
  endfunction

  state_t state_q, state_d;
  logic [4:0] cnt_q;
  logic [WIDTH-1:0] n_q, d_q, pc_q, rem_q, qres_q, rres_q;
  logic neg_q, accept;
  logic signed [WIDTH-1:0] n_s, d_s;

  assign n_s = Divident;
  assign d_s = Divisor;

  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    AccBusy      = 1'b0;
    AccMemWrEn   = 1'b0;
    AccMemAddr   = '0;
    AccMemWrData = '0;
    AccDWrEn     = 1'b0;
    AccDData     = '0;
    AccPcWrEn    = 1'b0;
    AccPc        = '0;
    case (state_q)
      S_IDLE: begin
        if (StartDiv102 && (d_s > 0)) begin
          accept  = 1'b1;
          state_d = (n_s <= 0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        AccBusy = 1'b1;
        if (Abort)              state_d = S_IDLE;
        else if (cnt_q == 5'd0) state_d = S_FIX;
      end
      S_FIX: begin
        AccBusy = 1'b1;
        state_d = Abort ? S_IDLE : S_WRQ;
      end
      S_WRQ: begin
        AccBusy      = 1'b1;
        AccMemWrEn   = 1'b1;
        AccMemAddr   = WIDTH'(Q_ADDR);
        AccMemWrData = qres_q;
        state_d      = S_WRR;
      end
      S_WRR: begin
        AccBusy      = 1'b1;
        AccMemWrEn   = 1'b1;
        AccMemAddr   = WIDTH'(R_ADDR);
        AccMemWrData = rres_q;
        AccDWrEn     = 1'b1;
        AccDData     = rres_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        AccPcWrEn = 1'b1;
        AccPc     = pc_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset)                 cnt_q <= '0;
    else if (accept)            cnt_q <= CNT_INIT;
    else if (state_q == S_CALC) cnt_q <= cnt_q - 5'd1;
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      n_q   <= Divident;
      d_q   <= Divisor;
      pc_q  <= ExitPc;
      rem_q <= '0;
      neg_q <= (n_s <= 0);
    end else if (state_q == S_CALC) begin
      {rem_q, n_q} <= div_step(rem_q, n_q, d_q);
    end else if (state_q == S_FIX) begin
      {qres_q, rres_q} <= fix_result(neg_q, n_q, rem_q, d_q);
    end
  end

  // Architectural result registers commit together with the remainder write.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Quotient  <= '0;
      Remainder <= '0;
    end else if (state_q == S_WRR) begin
      Quotient  <= qres_q;
      Remainder <= rres_q;
    end
  end

endmodule
